// File: rtl/fpu_op_feeder_if.sv
// fpu_op_feeder_if: producer-side operand handshake and consumer-side result
// handshake of the fpu operand feeder, bundled so they travel as one port.
// master = the environment (producer + consumer), slave = the feeder itself.
interface fpu_op_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_status;

  modport master (
    output in_valid, in_op_a, in_op_b, out_ready,
    input  in_ready, out_valid, out_result, out_status
  );

  modport slave (
    input  in_valid, in_op_a, in_op_b, out_ready,
    output in_ready, out_valid, out_result, out_status
  );
endinterface

// File: rtl/fpu_op_feeder.sv
// fpu_op_feeder: queues operand pairs in a small FIFO, holds one pair at a time
// on registered fpu inputs for HOLD_CYCLES clocks, then captures the fpu result
// and status and offers them to a consumer over valid/ready.
// Optional build macro FPU_FEEDER_STICKY_EN adds sticky_clr / sticky_status,
// an OR-accumulation of every captured status word.
module fpu_op_feeder #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                   clock100KHz,
  input  logic                   reset,
  fpu_op_feeder_if.slave         bus,
  output logic [31:0]            fpu_op_a,
  output logic [31:0]            fpu_op_b,
  input  logic [31:0]            fpu_data_in,
  input  logic [3:0]             fpu_status_in,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
`ifdef FPU_FEEDER_STICKY_EN
  ,
  input  logic                   sticky_clr,
  output logic [3:0]             sticky_status
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, OUTPUT} state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] hold_cnt;
  logic          push;
  logic          pop;
  logic          capture;
  logic          accept;

  assign bus.in_ready = (fifo_count < FULL_COUNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (fifo_count != '0);
  assign capture      = (state == WAIT) && (hold_cnt == '0);
  assign accept       = (state == OUTPUT) && bus.out_valid && bus.out_ready;
  assign busy         = (state != IDLE);

  // Operand storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock100KHz) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_op_a;
      mem_b[wr_ptr] <= bus.in_op_b;
    end
  end

  // FIFO pointers and occupancy; a same-edge push and pop leaves the count alone.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: issue, hold, then wait for the consumer to take the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop)     state_next = WAIT;
      WAIT:    if (capture) state_next = OUTPUT;
      OUTPUT:  if (accept)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue registers, hold countdown and result capture/handoff.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      fpu_op_a       <= '0;
      fpu_op_b       <= '0;
      hold_cnt       <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_status <= '0;
    end else begin
      if (pop) begin
        fpu_op_a <= mem_a[rd_ptr];
        fpu_op_b <= mem_b[rd_ptr];
        hold_cnt <= HOLD_LOAD;
      end else if ((state == WAIT) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - CW'(1);
      end
      if (capture) begin
        bus.out_result <= fpu_data_in;
        bus.out_status <= fpu_status_in;
        bus.out_valid  <= 1'b1;
      end else if (accept) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end

`ifdef FPU_FEEDER_STICKY_EN
  // Sticky status accumulation; a clear on the capture edge takes priority.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset)          sticky_status <= '0;
    else if (sticky_clr) sticky_status <= '0;
    else if (capture)    sticky_status <= sticky_status | fpu_status_in;
  end
`endif

endmodule
